// File: rtl/fft_stage_scheduler.sv
// Frame scheduler for the SDF FFT pipeline: slot tracking, zero-pad completion, per-stage enables.
// Optional FFT_SCHED_ERR_CNT_EN adds a saturating 16-bit framing-error counter (err_cnt).
module fft_stage_scheduler #(
   parameter int unsigned LAYERS     = 5,
   parameter int unsigned STAGE_PIPE = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   output logic              pad,
   output logic [LAYERS-1:0] stage_en,
   output logic              out_valid,
   output logic              out_first,
   output logic              out_last,
   output logic              frame_err,
   output logic              busy
`ifdef FFT_SCHED_ERR_CNT_EN
   ,
   output logic [15:0]       err_cnt
`endif
);

   localparam int unsigned N = 1 << LAYERS;
   localparam int unsigned L = (N - 1) + LAYERS * STAGE_PIPE;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StPad  = 2'd2;

   // Cumulative delay-line length up to stage s plus the fixed per-stage pipeline.
   function automatic int unsigned stage_off(input int unsigned s);
      int unsigned o;
      o = 0;
      for (int unsigned k = 0; k <= s; k++) begin
         o += 1 << (LAYERS - 1 - k);
      end
      return o + s * STAGE_PIPE;
   endfunction

   logic [1:0]        state_q, state_d;
   logic [LAYERS-1:0] cnt_q, cnt_d;
   logic [LAYERS-1:0] out_cnt_q;
   logic [L-1:0]      slot_sr;
   logic              err_q, err_d;
   logic              acc, slot, cnt_max;

   always_comb begin
      in_ready = (state_q != StPad);
      pad      = ((state_q == StRun) && !in_valid) || (state_q == StPad);
      acc      = in_valid && in_ready;
      slot     = acc || pad;
      cnt_max  = &cnt_q;
      state_d  = state_q;
      cnt_d    = cnt_q;
      if (slot) begin
         if (cnt_max) begin
            state_d = StIdle;
            cnt_d   = '0;
         end else begin
            state_d = pad ? StPad : StRun;
            cnt_d   = cnt_q + 1'b1;
         end
      end
      err_d = ((state_q == StRun) && !in_valid && !cnt_max) ||
              (acc && in_last && !cnt_max) ||
              (acc && !in_last && cnt_max);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         slot_sr <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         slot_sr <= {slot_sr[L-2:0], slot};
         err_q   <= err_d;
      end
   end

   // Every frame occupies exactly N contiguous slots, so a mod-N count of delayed
   // slots reproduces the input-side cnt at the output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_cnt_q <= '0;
      end else if (out_valid) begin
         out_cnt_q <= out_cnt_q + 1'b1;
      end
   end

   for (genvar s = 0; s < LAYERS; s++) begin : g_stage
      localparam int unsigned Off = stage_off(s);
      assign stage_en[s] = slot_sr[Off-1];
   end

   assign out_valid = slot_sr[L-1];
   assign out_first = out_valid && (out_cnt_q == '0);
   assign out_last  = out_valid && (&out_cnt_q);
   assign frame_err = err_q;
   assign busy      = (state_q != StIdle) || (|slot_sr);

`ifdef FFT_SCHED_ERR_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (err_q && (err_cnt != 16'hFFFF)) begin
         err_cnt <= err_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// Scoreboard bench for fft_stage_scheduler (LAYERS=5, STAGE_PIPE=3: O=16,27,34,39,43, L=46).
module tb_fft_stage_scheduler;

   localparam int LAT = 46;
   localparam int OFF [5] = '{16, 27, 34, 39, 43};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_last = 1'b0;
   logic       in_ready, pad, out_valid, out_first, out_last, frame_err, busy;
   logic [4:0] stage_en;
`ifdef FFT_SCHED_ERR_CNT_EN
   logic [15:0] err_cnt;
`endif

   fft_stage_scheduler #(
      .LAYERS     (5),
      .STAGE_PIPE (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .pad       (pad),
      .stage_en  (stage_en),
      .out_valid (out_valid),
      .out_first (out_first),
      .out_last  (out_last),
      .frame_err (frame_err),
      .busy      (busy)
`ifdef FFT_SCHED_ERR_CNT_EN
      ,
      .err_cnt   (err_cnt)
`endif
   );

   typedef struct {
      int at;
      bit first;
      bit last;
   } out_t;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   bit   exp_slot [4096];
   bit   exp_err [4096];
   bit   exp_pad = 1'b0;
   bit   exp_rdy = 1'b1;
   out_t exp_q [$];
   out_t o;
   logic [4:0] e_en;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
      end
   endtask

   // Monitor: per-cycle comparison against the expectations the stimulus recorded.
   always @(negedge clk) begin
      for (int s = 0; s < 5; s++) begin
         e_en[s] = (cyc >= OFF[s]) ? exp_slot[cyc-OFF[s]] : 1'b0;
      end
      check_eq("stage_en", stage_en, e_en);
      check_eq("pad", pad, exp_pad);
      check_eq("in_ready", in_ready, exp_rdy);
      check_eq("frame_err", frame_err, exp_err[cyc]);
      while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
         o = exp_q.pop_front();
         check_eq("out_valid_missing", cyc, o.at);
      end
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            check_eq("out_valid_spurious", out_valid, 1'b0);
         end else begin
            o = exp_q.pop_front();
            check_eq("out_cycle", cyc, o.at);
            check_eq("out_first", out_first, o.first);
            check_eq("out_last", out_last, o.last);
         end
      end else begin
         check_eq("out_markers_idle", {out_first, out_last}, 2'b00);
      end
   end

   task automatic step(input logic v, input logic l, input bit slot, input bit first,
                       input bit last, input bit epad, input bit erdy);
      @(posedge clk);
      #1;
      in_valid = v;
      in_last  = l;
      exp_pad  = epad;
      exp_rdy  = erdy;
      if (slot) begin
         exp_slot[cyc] = 1'b1;
         exp_q.push_back(out_t'{cyc + LAT, first, last});
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   // gap_at < 0: no gap. The source keeps in_valid high through the pad run.
   task automatic send_frame(input int gap_at, input int last_at);
      for (int i = 0; i < 32; i++) begin
         bit g;
         bit l;
         g = (gap_at >= 0) && (i >= gap_at);
         l = !g && ((i == last_at) || (i == 31));
         step(i != gap_at, l, 1'b1, i == 0, i == 31, g, !(g && (i > gap_at)));
         if ((i == gap_at) || (l && (i != 31))) exp_err[cyc+1] = 1'b1;
      end
   endtask

   task automatic check_idle(input string name);
      @(negedge clk);
      check_eq({name, "_busy"}, busy, 1'b0);
      check_eq({name, "_pad"}, pad, 1'b0);
      check_eq({name, "_stage_en"}, stage_en, 5'd0);
      check_eq({name, "_out_valid"}, out_valid, 1'b0);
   endtask

   task automatic reset_mid_frame();
      for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b1, i == 0, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      rst      = 1'b1;
      in_valid = 1'b0;
      exp_pad  = 1'b0;
      exp_rdy  = 1'b1;
      for (int c = 0; c <= cyc; c++) exp_slot[c] = 1'b0;
      exp_q.delete();
      #1;
      check_eq("rst_stage_en", stage_en, 5'd0);
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_in_ready", in_ready, 1'b1);
      check_eq("rst_busy", busy, 1'b0);
      idle(2);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(5);
      check_idle("idle_after_reset");

      send_frame(-1, 31);
      @(negedge clk);
      check_eq("busy_active", busy, 1'b1);
      idle(50);
      check_idle("idle_single");

      repeat (3) send_frame(-1, 31);
      idle(50);
      check_idle("idle_b2b");

      send_frame(-1, 20);
      idle(50);
`ifdef FFT_SCHED_ERR_CNT_EN
      check_eq("err_cnt", err_cnt, 16'd1);
`endif

      send_frame(10, 31);
      send_frame(-1, 31);
      idle(50);
      check_idle("idle_gap");

      reset_mid_frame();
      send_frame(-1, 31);
      idle(50);
      check_idle("idle_post_reset");

      check_eq("scoreboard_drain", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
